// File: rtl/bram_capture_ctrl.sv
// Write-side sequencer for the 64-bit capture BRAM: arm, wait for trigger, write N samples, flag done.
// Optional decimation is built only when BRAM_CAPTURE_DECIM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | run parameters latched, waiting for trig
// CAPTURE | accepting samples into consecutive addresses
// DONE    | target reached, buffer ready for readout
module bram_capture_ctrl #(
  parameter int DEPTH   = 16384,
  parameter int AW      = 14,
  parameter int DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig,
  input  logic [AW:0]        n_samples,
  input  logic [DECIM_W-1:0] decim,
  input  logic               sample_valid,
  input  logic [63:0]        sample_in,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [63:0]        wdata,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      wr_count_q, wr_count_d;
  logic [AW:0]      target_q, target_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             start;
  logic             accept;
  logic             last;

  assign start = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef BRAM_CAPTURE_DECIM_EN
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [DECIM_W-1:0] dcnt_q, dcnt_d;

  // Counter is cleared on arm, so the first valid sample of a run is always taken.
  always_comb begin
    accept  = (state_q == S_CAPTURE) && sample_valid && (dcnt_q == '0);
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    if (start) begin
      decim_d = decim;
      dcnt_d  = '0;
    end else if ((state_q == S_CAPTURE) && sample_valid) begin
      dcnt_d = accept ? decim_q : (dcnt_q - DECIM_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decim_q <= '0;
      dcnt_q  <= '0;
    end else begin
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
    end
  end
`else
  logic decim_unused;
  assign decim_unused = ^decim;

  always_comb begin
    accept = (state_q == S_CAPTURE) && sample_valid;
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    target_d   = target_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    last       = accept && ((wr_count_q + (AW+1)'(1)) == target_q);

    if (start) begin
      addr_d     = '0;
      wr_count_d = '0;
      target_d   = ((n_samples == '0) || (n_samples > DEPTH_V)) ? DEPTH_V : n_samples;
    end

    // An accept in the abort cycle still commits its write.
    if (accept) begin
      we_d       = 1'b1;
      waddr_d    = addr_q;
      wdata_d    = sample_in;
      addr_d     = addr_q + AW'(1);
      wr_count_d = wr_count_q + (AW+1)'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ARMED;
      S_ARMED:        if (trig)  state_d = S_CAPTURE;
      S_CAPTURE:      if (last)  state_d = S_DONE;
      default:                   state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_count_q <= '0;
      target_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_count_q <= wr_count_d;
      target_q   <= target_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wr_count = wr_count_q;
  assign armed    = (state_q == S_ARMED);
  assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Scoreboard bench for bram_capture_ctrl: expected writes are queued by the stimulus,
// a negedge monitor pops and compares on every we.
module tb_bram_capture_ctrl;

  localparam int DEPTH   = 16384;
  localparam int AW      = 14;
  localparam int DECIM_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               arm, abort, trig;
  logic [AW:0]        n_samples;
  logic [DECIM_W-1:0] decim;
  logic               sample_valid;
  logic [63:0]        sample_in;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [63:0]        wdata;
  logic               armed, busy, done;
  logic [AW:0]        wr_count;

  bram_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .DECIM_W(DECIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
    .n_samples(n_samples), .decim(decim), .sample_valid(sample_valid),
    .sample_in(sample_in), .we(we), .waddr(waddr), .wdata(wdata),
    .armed(armed), .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+63:0] exp_q[$];

  always @(negedge clk) begin
    logic [AW+63:0] e;
    if (we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e[AW+63:64] || wdata !== e[63:0]) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   waddr, wdata, e[AW+63:64], e[63:0]);
        end
      end
    end
  end

  task automatic push(input int a, input logic [63:0] d);
    logic [31:0] av;
    av = a;
    exp_q.push_back({av[AW-1:0], d});
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input int d);
    n_samples = (AW+1)'(n);
    decim     = DECIM_W'(d);
    arm = 1'b1;
    cyc();
    arm  = 1'b0;
    trig = 1'b1;
    cyc();
    trig = 1'b0;
  endtask

  function automatic logic [63:0] any_out();
    return 64'(we | armed | busy | done | (|waddr) | (|wdata) | (|wr_count));
  endfunction

  initial begin
    int exp_dec[4];
    int exp_gate[2];
`ifdef BRAM_CAPTURE_DECIM_EN
    exp_dec  = '{0, 3, 6, 9};
    exp_gate = '{0, 4};
`else
    exp_dec  = '{0, 1, 2, 3};
    exp_gate = '{0, 2};
`endif
    rst_n = 1'b0; arm = 0; abort = 0; trig = 0;
    n_samples = '0; decim = '0; sample_valid = 0; sample_in = '0;
    repeat (3) cyc();
    check("reset_outputs_zero", any_out(), 64'd0);
    rst_n = 1'b1;
    cyc();

    // basic run
    n_samples = 8; decim = 0; arm = 1'b1;
    cyc();
    arm = 1'b0;
    check("armed_after_arm", {armed, busy, done}, 64'b110);
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    check("capture_busy", {armed, busy, done}, 64'b010);
    for (int i = 0; i < 8; i++) push(i, 64'h100 + 64'(i));
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'h100 + 64'(i);
      cyc();
      if (i == 7) begin
        check("basic_done_with_last_we", {we, done, busy}, 64'b110);
        check("basic_wr_count", 64'(wr_count), 64'd8);
      end
    end
    sample_valid = 1'b0;
    check("basic_done_holds", 64'(done), 64'd1);

    // decimation
    start_run(4, 2);
    for (int i = 0; i < 4; i++) push(i, 64'(exp_dec[i]));
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'(i);
      cyc();
    end
    sample_valid = 1'b0;
    check("decim_wr_count", 64'(wr_count), 64'd4);
    check("decim_done", 64'(done), 64'd1);

    // gated valid
    start_run(2, 1);
    for (int i = 0; i < 2; i++) push(i, 64'(exp_gate[i]));
    for (int i = 0; i < 8; i++) begin
      sample_valid = (i % 2 == 0);
      sample_in = 64'(i);
      cyc();
    end
    sample_valid = 1'b0;
    check("gated_wr_count", 64'(wr_count), 64'd2);
    check("gated_done", 64'(done), 64'd1);

    // clamp: n=0 then n=DEPTH+5
    for (int r = 0; r < 2; r++) begin
      start_run((r == 0) ? 0 : DEPTH + 5, 0);
      for (int i = 0; i < DEPTH + 3; i++) begin
        sample_valid = 1'b1;
        sample_in = 64'(i) + 64'(r << 20);
        if (i < DEPTH) push(i, sample_in);
        cyc();
        if (i == DEPTH - 1) begin
          check("clamp_last_waddr", 64'(waddr), 64'(DEPTH - 1));
          check("clamp_done_count", {63'(wr_count), done}, {63'(DEPTH), 1'b1});
        end
      end
      sample_valid = 1'b0;
    end

    // abort after 3 writes
    start_run(10, 0);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'hA0 + 64'(i);
      push(i, sample_in);
      cyc();
    end
    sample_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_idle", {armed, busy, done}, 64'b000);
    check("abort_wr_count", 64'(wr_count), 64'd3);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'hBAD;
      cyc();
    end
    sample_valid = 1'b0;

    // arm+abort together from DONE
    start_run(1, 0);
    sample_valid = 1'b1; sample_in = 64'hAA; push(0, 64'hAA);
    cyc();
    sample_valid = 1'b0;
    check("single_done", 64'(done), 64'd1);
    arm = 1'b1; abort = 1'b1;
    cyc();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", {armed, busy, done}, 64'b000);
    check("arm_abort_wr_count", 64'(wr_count), 64'd1);
    cyc();
    check("arm_abort_not_armed", 64'(armed), 64'd0);

    // arm during capture is ignored
    start_run(6, 0);
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'h200 + 64'(i);
      arm = (i == 2);
      if (i < 6) push(i, sample_in);
      cyc();
      if (i == 5) check("rearm_done_count", {63'(wr_count), done}, {63'd6, 1'b1});
    end
    arm = 1'b0; sample_valid = 1'b0;

    // reset mid-capture
    start_run(6, 0);
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1;
      sample_in = 64'h300 + 64'(i);
      push(i, sample_in);
      cyc();
    end
    rst_n = 1'b0; sample_in = 64'h302;
    cyc();
    check("reset_mid_capture_zero", any_out(), 64'd0);
    rst_n = 1'b1; sample_valid = 1'b0;
    cyc();
    start_run(1, 0);
    sample_valid = 1'b1; sample_in = 64'h55; push(0, 64'h55);
    cyc();
    sample_valid = 1'b0;
    check("restart_waddr0", {63'(waddr), we}, {63'd0, 1'b1});

    repeat (2) cyc();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
